// File: rtl/unsigned_result_stage.sv
// ---------------------------------------------------------------------------
// unsigned_result_stage
//
// Sequencing and result-buffering stage that sits directly behind the
// combinational unsigned arithmetic unit (add/sub/mul/div). It accepts one
// operation at a time and drives the unit's opcode from a register. It then
// waits a per-opcode settle time so the slow multiply/divide paths can
// resolve, captures the 32-bit answer, and queues it in a small FIFO. The
// FIFO hands results to writeback over a valid/ready interface.
//
// Parameters:
//   DEPTH    result FIFO entries (power of two, >= 2)
//   ADD_WAIT settle cycles for opcodes 00 (sum) and 01 (difference)
//   MUL_WAIT settle cycles for opcode 10 (product, low 32 bits)
//   DIV_WAIT settle cycles for opcode 11 (quotient)
//
// Ports:
//   clk           single clock, rising-edge
//   reset         synchronous, active-high reset
//   req_valid_i   operation request valid
//   req_ready_o   stage can accept a request
//   req_opcode_i  00 sum, 01 difference, 10 product, 11 quotient
//   req_b_i       copy of operand B (only used by the divide-by-zero flag)
//   alu_opcode_o  opcode driven to the unsigned unit
//   alu_answer_i  answer from the unsigned unit
//   res_valid_o   FIFO head valid
//   res_ready_i   writeback accepts the head entry
//   res_data_o    head answer (0 when empty)
//   res_opcode_o  head opcode (0 when empty)
//   res_zero_o    head answer == 0 (0 when empty)
//   res_divzero_o head divide-by-zero flag (only with UNSIGNED_DIVZERO_FLAG_EN)
//   res_count_o   FIFO occupancy
//
// Optional feature (macro UNSIGNED_DIVZERO_FLAG_EN):
//   A quotient request whose B operand is zero is flagged at accept time. Its
//   result is forced to 32'hFFFFFFFF with res_zero low, and the flag travels
//   through the FIFO to res_divzero_o.
// ---------------------------------------------------------------------------
module unsigned_result_stage #(
    parameter int DEPTH    = 4,
    parameter int ADD_WAIT = 0,
    parameter int MUL_WAIT = 3,
    parameter int DIV_WAIT = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_opcode_i,
    input  logic [31:0]                  req_b_i,
    output logic [1:0]                   alu_opcode_o,
    input  logic [31:0]                  alu_answer_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [31:0]                  res_data_o,
    output logic [1:0]                   res_opcode_o,
    output logic                         res_zero_o,
`ifdef UNSIGNED_DIVZERO_FLAG_EN
    output logic                         res_divzero_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   res_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t             state_q;
    logic [3:0]         waitCnt_q;
    logic [1:0]         op_q;

    logic               accept;
    logic               push;
    logic               pop;
    logic [31:0]        pushData;
    logic               pushZero;

    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [PTR_W-1:0]   rdPtr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    logic [31:0]        dataMem [DEPTH];
    logic [1:0]         opMem   [DEPTH];
    logic               zeroMem [DEPTH];

`ifdef UNSIGNED_DIVZERO_FLAG_EN
    logic               dz_q;
    logic               dzMem   [DEPTH];
`else
    logic               unusedReqB;
    assign unusedReqB = ^req_b_i;
`endif

    // Settle time for an opcode: sum and difference share the short wait.
    function automatic logic [3:0] settleFor(input logic [1:0] op);
        case (op)
            2'b10:   settleFor = 4'(MUL_WAIT);
            2'b11:   settleFor = 4'(DIV_WAIT);
            default: settleFor = 4'(ADD_WAIT);
        endcase
    endfunction

    // A request is taken only from IDLE with room in the FIFO. Because only
    // one op can be in flight, this alone guarantees a capture never finds
    // the FIFO full, so no overflow handling is needed.
    assign req_ready_o  = (state_q == IDLE) && (count_q < FULL_COUNT);
    assign accept       = req_valid_i && req_ready_o;
    assign push         = (state_q == SETTLE) && (waitCnt_q == 4'd0);
    assign res_valid_o  = (count_q != '0);
    assign pop          = res_valid_o && res_ready_i;
    assign alu_opcode_o = op_q;
    assign res_count_o  = count_q;

    // Capture value for the FIFO. A flagged divide-by-zero replaces the
    // unit's meaningless quotient with all ones and never reports zero.
    always_comb begin
        pushData = alu_answer_i;
        pushZero = (alu_answer_i == 32'd0);
`ifdef UNSIGNED_DIVZERO_FLAG_EN
        if (dz_q) begin
            pushData = 32'hFFFF_FFFF;
            pushZero = 1'b0;
        end
`endif
    end

    // Sequencer: latch the opcode (and divide-by-zero flag) on accept, count
    // the settle time down, and return to IDLE on the capture edge. The
    // opcode register stays put between accepts so the unit sees a stable
    // opcode for the whole settle window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            op_q      <= 2'b00;
`ifdef UNSIGNED_DIVZERO_FLAG_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= req_opcode_i;
                        waitCnt_q <= settleFor(req_opcode_i);
                        state_q   <= SETTLE;
`ifdef UNSIGNED_DIVZERO_FLAG_EN
                        dz_q      <= (req_opcode_i == 2'b11) && (req_b_i == 32'd0);
`endif
                    end
                end
                SETTLE: begin
                    if (waitCnt_q != 4'd0) begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // FIFO pointer and occupancy update. A simultaneous push and pop moves
    // both pointers and leaves the count alone. Pointer arithmetic wraps
    // naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers. Reset drops all queued results.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Result storage. It is not reset; the empty mask on the outputs hides
    // stale entries.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            dataMem[wrPtr_q] <= pushData;
            opMem[wrPtr_q]   <= op_q;
            zeroMem[wrPtr_q] <= pushZero;
`ifdef UNSIGNED_DIVZERO_FLAG_EN
            dzMem[wrPtr_q]   <= dz_q;
`endif
        end
    end

    // Head entry presented to writeback, forced to zero while empty.
    always_comb begin
        res_data_o   = 32'd0;
        res_opcode_o = 2'b00;
        res_zero_o   = 1'b0;
`ifdef UNSIGNED_DIVZERO_FLAG_EN
        res_divzero_o = 1'b0;
`endif
        if (res_valid_o) begin
            res_data_o   = dataMem[rdPtr_q];
            res_opcode_o = opMem[rdPtr_q];
            res_zero_o   = zeroMem[rdPtr_q];
`ifdef UNSIGNED_DIVZERO_FLAG_EN
            res_divzero_o = dzMem[rdPtr_q];
`endif
        end
    end

endmodule

// File: tb/tb_unsigned_result_stage.sv
// ---------------------------------------------------------------------------
// tb_unsigned_result_stage
//
// Drives requests into unsigned_result_stage while a behavioural stand-in for
// the arithmetic unit answers from the registered opcode. Each request pushes
// its expected result onto a queue. An independent monitor pops that queue
// whenever writeback takes the head entry and compares the two.
// ---------------------------------------------------------------------------
module tb_unsigned_result_stage;

    localparam int DEPTH    = 4;
    localparam int ADD_WAIT = 0;
    localparam int MUL_WAIT = 3;
    localparam int DIV_WAIT = 7;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
        logic        zero;
        logic        dz;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             reqValid;
    logic             reqReady;
    logic [1:0]       reqOpcode;
    logic [31:0]      reqB;
    logic [1:0]       aluOpcode;
    logic [31:0]      aluAnswer;
    logic             resValid;
    logic             resReady;
    logic [31:0]      resData;
    logic [1:0]       resOpcode;
    logic             resZero;
    logic [CNT_W-1:0] resCount;
`ifdef UNSIGNED_DIVZERO_FLAG_EN
    logic             resDivzero;
`endif

    logic [31:0]      aOp;
    logic [31:0]      bOp;
    exp_t             expQ[$];
    exp_t             headExp;
    int               checks;
    int               errors;
    bit               randomBp;

    unsigned_result_stage #(
        .DEPTH   (DEPTH),
        .ADD_WAIT(ADD_WAIT),
        .MUL_WAIT(MUL_WAIT),
        .DIV_WAIT(DIV_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_opcode_i (reqOpcode),
        .req_b_i      (reqB),
        .alu_opcode_o (aluOpcode),
        .alu_answer_i (aluAnswer),
        .res_valid_o  (resValid),
        .res_ready_i  (resReady),
        .res_data_o   (resData),
        .res_opcode_o (resOpcode),
        .res_zero_o   (resZero),
`ifdef UNSIGNED_DIVZERO_FLAG_EN
        .res_divzero_o(resDivzero),
`endif
        .res_count_o  (resCount)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational unsigned unit. A zero divisor returns 0
    // here so a forced all-ones result is distinguishable from the unit's.
    function automatic logic [31:0] unitAnswer(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            2'b00: unitAnswer = a + b;
            2'b01: unitAnswer = a - b;
            2'b10: begin
                wide = {32'd0, a} * {32'd0, b};
                unitAnswer = wide[31:0];
            end
            default: unitAnswer = (b == 32'd0) ? 32'd0 : a / b;
        endcase
    endfunction

    assign aluAnswer = unitAnswer(aluOpcode, aOp, bOp);

    function automatic int settleFor(input logic [1:0] op);
        case (op)
            2'b10:   settleFor = MUL_WAIT;
            2'b11:   settleFor = DIV_WAIT;
            default: settleFor = ADD_WAIT;
        endcase
    endfunction

    // Expected FIFO entry for a request, taken from the arithmetic meaning
    // of the opcode.
    function automatic exp_t referenceResult(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        exp_t r;
        longint unsigned prod;
        r.op = op;
        r.dz = 1'b0;
        case (op)
            2'b00: r.data = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            2'b01: r.data = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            2'b10: begin
                prod = longint'(a) * longint'(b);
                r.data = 32'(prod % 64'h1_0000_0000);
            end
            default: r.data = (b == 32'd0) ? 32'd0 : a / b;
        endcase
        r.zero = (r.data == 32'd0);
`ifdef UNSIGNED_DIVZERO_FLAG_EN
        if (op == 2'b11 && b == 32'd0) begin
            r.data = 32'hFFFF_FFFF;
            r.zero = 1'b0;
            r.dz   = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issue one request. Called at #1 after a rising edge and returns at #1
    // after the accept edge, or after the capture when timing is checked.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit checkTiming);
        int guard;
        int edges;
        int holdBad;
        guard = 0;
        while (!reqReady && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("req_ready before issue", reqReady, 1);
        aOp       = a;
        bOp       = b;
        reqB      = b;
        reqOpcode = op;
        reqValid  = 1'b1;
        expQ.push_back(referenceResult(op, a, b));
        @(posedge clk); #1;
        reqValid  = 1'b0;
        reqOpcode = 2'($urandom_range(0, 3));
        reqB      = $urandom;
        if (checkTiming) begin
            edges   = 0;
            holdBad = 0;
            while (!reqReady && edges < 40) begin
                if (aluOpcode !== op) holdBad++;
                @(posedge clk); #1;
                edges++;
            end
            checkOutput("settle edges to capture", edges, settleFor(op) + 1);
            checkOutput("alu_opcode held in settle", holdBad, 0);
            checkOutput("alu_opcode after capture", aluOpcode, op);
        end
    endtask

    // Release back-pressure and wait until every expected result is taken.
    task automatic drain();
        int guard;
        guard    = 0;
        randomBp = 1'b0;
        #2;
        resReady = 1'b1;
        while ((expQ.size() != 0 || resValid) && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk); #1;
        checkOutput("drain completes", (guard < 300), 1);
    endtask

    // Random writeback back-pressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (randomBp) resReady = 1'($urandom_range(0, 1));
    end

    // Monitor: compare each popped head against the scoreboard, and check the
    // empty-FIFO output values whenever nothing is queued.
    always @(negedge clk) begin
        if (!reset) begin
            if (resValid) begin
                if (resReady) begin
                    if (expQ.size() == 0) begin
                        checkOutput("pop with empty scoreboard", expQ.size(), 1);
                    end else begin
                        headExp = expQ.pop_front();
                        checkOutput("res_data", resData, headExp.data);
                        checkOutput("res_opcode", resOpcode, headExp.op);
                        checkOutput("res_zero", resZero, headExp.zero);
`ifdef UNSIGNED_DIVZERO_FLAG_EN
                        checkOutput("res_divzero", resDivzero, headExp.dz);
`endif
                    end
                end
            end else begin
                checkOutput("empty res_data", resData, 0);
                checkOutput("empty res_opcode", resOpcode, 0);
                checkOutput("empty res_zero", resZero, 0);
            end
        end
    end

    // Global bound on simulation time.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios, then a randomized run.
    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks    = 0;
        errors    = 0;
        randomBp  = 1'b0;
        reset     = 1'b1;
        reqValid  = 1'b0;
        reqOpcode = 2'b00;
        reqB      = 32'd0;
        aOp       = 32'd0;
        bOp       = 32'd0;
        resReady  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset req_ready", reqReady, 1);
        checkOutput("reset res_valid", resValid, 0);
        checkOutput("reset res_count", resCount, 0);
        checkOutput("reset alu_opcode", aluOpcode, 0);

        // Sum, answer visible one edge after accept, popped on the next.
        resReady = 1'b1;
        applyStimulus(2'b00, 32'd5, 32'd7, 1'b1);
        checkOutput("sum res_valid after capture", resValid, 1);
        checkOutput("sum res_count after capture", resCount, 1);
        @(posedge clk); #1;
        checkOutput("sum res_count after pop", resCount, 0);

        // Quotient with the long settle window.
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b1);
        drain();

        // Fill the FIFO under back-pressure.
        resReady = 1'b0;
        applyStimulus(2'b01, 32'd11, 32'd10, 1'b1);
        applyStimulus(2'b01, 32'd5, 32'd3, 1'b1);
        applyStimulus(2'b01, 32'd10, 32'd7, 1'b1);
        applyStimulus(2'b01, 32'd9, 32'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("full res_count", resCount, DEPTH);
        checkOutput("full req_ready", reqReady, 0);
        checkOutput("full head data", resData, 1);

        // Pending request while full, then a single pop lets it in.
        reqValid  = 1'b1;
        reqOpcode = 2'b10;
        @(posedge clk); #1;
        checkOutput("full pending req_ready", reqReady, 0);
        checkOutput("full pending res_count", resCount, DEPTH);
        reqValid = 1'b0;
        resReady = 1'b1;
        @(posedge clk); #1;
        resReady = 1'b0;
        checkOutput("req_ready after first pop", reqReady, 1);
        checkOutput("res_count after first pop", resCount, DEPTH - 1);
        applyStimulus(2'b10, 32'd6, 32'd7, 1'b0);
        repeat (MUL_WAIT) begin
            @(posedge clk); #1;
        end
        resReady = 1'b1;
        @(posedge clk); #1;
        resReady = 1'b0;
        checkOutput("count on push with pop", resCount, DEPTH - 1);
        drain();

        // Reset during a quotient settle discards everything.
        applyStimulus(2'b11, 32'd50, 32'd5, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid-settle reset req_ready", reqReady, 1);
        checkOutput("mid-settle reset res_valid", resValid, 0);
        checkOutput("mid-settle reset res_count", resCount, 0);
        checkOutput("mid-settle reset alu_opcode", aluOpcode, 0);
        repeat (12) begin
            @(posedge clk); #1;
        end
        checkOutput("no push after reset", resCount, 0);

`ifdef UNSIGNED_DIVZERO_FLAG_EN
        applyStimulus(2'b11, 32'd77, 32'd0, 1'b1);
        applyStimulus(2'b11, 32'd9, 32'd3, 1'b1);
        drain();
`endif

        // Randomized run with random back-pressure.
        randomBp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            if (op == 2'b11) begin
                b = $urandom_range(1, 1000);
`ifdef UNSIGNED_DIVZERO_FLAG_EN
                if ($urandom_range(0, 5) == 0) b = 32'd0;
`endif
            end
            applyStimulus(op, a, b, 1'b0);
        end
        drain();
        checkOutput("final res_count", resCount, 0);
        checkOutput("final req_ready", reqReady, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
